ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle shared by the two RAM masters, the arbiter and the RAM.
// The slave side is the arbiter; the master side is everything around it.
interface ram_arbiter_if #(
    parameter int adlines   = 8,
    parameter int datalines = 16
);
    logic                 fixed_prio;

    logic                 m0_req;
    logic                 m0_we;
    logic [adlines-1:0]   m0_addr;
    logic [datalines-1:0] m0_wdata;
    logic                 m0_gnt;
    logic                 m0_done;
    logic [datalines-1:0] m0_rdata;

    logic                 m1_req;
    logic                 m1_we;
    logic [adlines-1:0]   m1_addr;
    logic [datalines-1:0] m1_wdata;
    logic                 m1_gnt;
    logic                 m1_done;
    logic [datalines-1:0] m1_rdata;

    logic [adlines-1:0]   ram_addr;
    logic                 ram_read;
    logic                 ram_write;
    logic [datalines-1:0] ram_wdata;
    logic [datalines-1:0] ram_rdata;

    modport slave (
        input  fixed_prio,
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_rdata,
        output m0_gnt, m0_done, m0_rdata,
        output m1_gnt, m1_done, m1_rdata,
        output ram_addr, ram_read, ram_write, ram_wdata
    );

    modport master (
        output fixed_prio,
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_rdata,
        input  m0_gnt, m0_done, m0_rdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  ram_addr, ram_read, ram_write, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM.
// Each access takes three cycles: grant (IDLE), strobe (ACCESS), done (RESP).
// Read data from the RAM arrives in RESP and is passed straight through to
// the winner's rdata with done, then held in a per-port register.
module ram_arbiter #(
    parameter int adlines   = 8,
    parameter int datalines = 16
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 any_req_s;
    logic                 win_s;      // 0 = port 0, 1 = port 1
    logic                 win_r;
    logic                 we_r;
    logic                 last_r;     // port granted most recently
    logic [adlines-1:0]   addr_r;
    logic [datalines-1:0] wdata_r;
    logic [datalines-1:0] rdata0_r;
    logic [datalines-1:0] rdata1_r;

    assign any_req_s     = bus.m0_req | bus.m1_req;
    assign bus.ram_addr  = addr_r;
    assign bus.ram_wdata = wdata_r;

    // Pick the winner among the current requests (only used in IDLE)
    always_comb begin
        win_s = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            if (bus.fixed_prio) begin
                win_s = 1'b0;
            end else begin
                win_s = ~last_r;
            end
        end else if (bus.m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE waits for a request, then a fixed two-cycle access
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Latch the winning request and remember who was granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r   <= 1'b0;
            we_r    <= 1'b0;
            last_r  <= 1'b0;
            addr_r  <= {adlines{1'b0}};
            wdata_r <= {datalines{1'b0}};
        end else if (state_r == IDLE && any_req_s) begin
            win_r   <= win_s;
            last_r  <= win_s;
            we_r    <= win_s ? bus.m1_we    : bus.m0_we;
            addr_r  <= win_s ? bus.m1_addr  : bus.m0_addr;
            wdata_r <= win_s ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    // Capture RAM read data into the winner's holding register at the end of RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_r <= {datalines{1'b0}};
            rdata1_r <= {datalines{1'b0}};
        end else if (state_r == RESP && !we_r) begin
            if (win_r) begin
                rdata1_r <= bus.ram_rdata;
            end else begin
                rdata0_r <= bus.ram_rdata;
            end
        end
    end

    // Output decode: grant in IDLE, strobe in ACCESS, done plus read bypass in RESP
    always_comb begin
        bus.m0_gnt    = 1'b0;
        bus.m1_gnt    = 1'b0;
        bus.m0_done   = 1'b0;
        bus.m1_done   = 1'b0;
        bus.ram_read  = 1'b0;
        bus.ram_write = 1'b0;
        bus.m0_rdata  = rdata0_r;
        bus.m1_rdata  = rdata1_r;
        case (state_r)
            IDLE: begin
                // rst gates the grant so nothing is accepted while reset is held
                if (any_req_s && !rst) begin
                    bus.m0_gnt = ~win_s;
                    bus.m1_gnt = win_s;
                end else begin
                    bus.m0_gnt = 1'b0;
                    bus.m1_gnt = 1'b0;
                end
            end
            ACCESS: begin
                bus.ram_read  = ~we_r;
                bus.ram_write = we_r;
            end
            RESP: begin
                bus.m0_done = ~win_r;
                bus.m1_done = win_r;
                if (!we_r) begin
                    if (win_r) begin
                        bus.m1_rdata = bus.ram_rdata;
                    end else begin
                        bus.m0_rdata = bus.ram_rdata;
                    end
                end else begin
                    bus.m0_rdata = rdata0_r;
                    bus.m1_rdata = rdata1_r;
                end
            end
            default: begin
                bus.ram_read  = 1'b0;
                bus.ram_write = 1'b0;
            end
        endcase
    end
endmodule
